// File: rtl/mem_bus_router.sv
// Byte-wide router: round-robin arbitration of N masters onto one RAM port and one IO port,
// with burst locking and IO-write stalls. Define MEM_ROUTER_PERF_EN to add access/stall counters.
module mem_bus_router #(
  parameter int N_MASTERS      = 2,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int ID_W           = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [N_MASTERS-1:0]      m_req,
  input  logic [N_MASTERS-1:0]      m_wr,
  input  logic [32*N_MASTERS-1:0]   m_a,
  input  logic [8*N_MASTERS-1:0]    m_dout,
  input  logic [N_MASTERS-1:0]      m_burst,
  output logic [N_MASTERS-1:0]      m_ack,
  output logic [N_MASTERS-1:0]      m_rvalid,
  output logic [7:0]                m_din,
  output logic                      ram_en,
  output logic                      ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_din,
  input  logic [7:0]                ram_dout,
  output logic                      io_en,
  output logic [2:0]                io_sel,
  output logic                      io_wr,
  output logic [7:0]                io_din,
  input  logic [7:0]                io_dout,
  input  logic                      io_full,
`ifdef MEM_ROUTER_PERF_EN
  output logic [31:0]               perf_ram_cnt,
  output logic [31:0]               perf_io_cnt,
  output logic [31:0]               perf_stall_cnt,
`endif
  output logic [ID_W-1:0]           grant_id
);

  logic [ID_W-1:0]      rr_ptr, owner, win;
  logic                 lock, owner_req, lock_eff, found;
  logic [31:0]          sel_a;
  logic [7:0]           sel_dout;
  logic                 sel_wr, sel_burst, sel_io, io_block, accept;
  logic [N_MASTERS-1:0] pend;
  logic                 pend_io;
  logic                 unused_a;

  // A lock only holds while its owner keeps requesting; a drop frees the bus this cycle.
  always_comb begin
    owner_req = 1'b0;
    for (int j = 0; j < N_MASTERS; j++)
      if (ID_W'(j) == owner) owner_req = m_req[j];
    lock_eff = lock && owner_req;
    found    = 1'b0;
    win      = '0;
    if (lock_eff) begin
      found = 1'b1;
      win   = owner;
    end else begin
      for (int j = 0; j < N_MASTERS; j++)
        if (!found && m_req[j] && (ID_W'(j) >= rr_ptr)) begin
          found = 1'b1;
          win   = ID_W'(j);
        end
      for (int j = 0; j < N_MASTERS; j++)
        if (!found && m_req[j]) begin
          found = 1'b1;
          win   = ID_W'(j);
        end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_dout  = '0;
    sel_wr    = 1'b0;
    sel_burst = 1'b0;
    for (int j = 0; j < N_MASTERS; j++)
      if (ID_W'(j) == win) begin
        sel_a     = m_a[32*j +: 32];
        sel_dout  = m_dout[8*j +: 8];
        sel_wr    = m_wr[j];
        sel_burst = m_burst[j];
      end
  end

  // Upper address bits play no part in decode.
  assign unused_a = ^sel_a[31:RAM_ADDR_WIDTH+1];

  assign sel_io   = (sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign io_block = sel_io && sel_wr && io_full;
  assign accept   = found && !io_block && !rst_in;

  always_comb begin
    m_ack = '0;
    for (int j = 0; j < N_MASTERS; j++)
      m_ack[j] = accept && (ID_W'(j) == win);
  end

  assign ram_en   = accept && !sel_io;
  assign ram_r_nw = !sel_wr;
  assign ram_a    = sel_a[RAM_ADDR_WIDTH-1:0];
  assign ram_din  = sel_dout;
  assign io_en    = accept && sel_io;
  assign io_sel   = sel_a[2:0];
  assign io_wr    = io_en && sel_wr;
  assign io_din   = sel_dout;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr   <= '0;
      owner    <= '0;
      lock     <= 1'b0;
      grant_id <= '0;
      pend     <= '0;
      pend_io  <= 1'b0;
    end else begin
      pend <= (accept && !sel_wr) ? m_ack : '0;
      if (accept) begin
        pend_io  <= sel_io;
        rr_ptr   <= (int'(win) == N_MASTERS-1) ? '0 : win + ID_W'(1);
        grant_id <= win;
        owner    <= win;
        lock     <= sel_burst && (N_MASTERS > 1);
      end else begin
        lock <= lock_eff;
      end
    end
  end

  // Region flag was captured with the read, so a new access can't steer returning data.
  assign m_rvalid = pend;
  assign m_din    = (|pend) ? (pend_io ? io_dout : ram_dout) : 8'h00;

`ifdef MEM_ROUTER_PERF_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_ram_cnt   <= '0;
      perf_io_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (ram_en) perf_ram_cnt <= perf_ram_cnt + 32'd1;
      if (io_en) perf_io_cnt <= perf_io_cnt + 32'd1;
      if (found && io_block) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Parametrised byte-wide memory/IO router that replaces the fixed CPU/HCI bus multiplexing in the top level.
- Arbitrates N_MASTERS requesters (e.g. cpu, hci, future DMA) onto one RAM port and one HCI IO port.
- Decodes the IO window from address bits and returns read data tagged with the requesting master.
- Supports burst locking and stalls IO writes on a full IO buffer, instead of dropping them.

Parameters:
- N_MASTERS, 2, number of requesting masters; master 0 is the CPU by convention.
- RAM_ADDR_WIDTH, 17, RAM byte-address width; IO window is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.
- ID_W, 1, width of grant_id; must satisfy 2**ID_W >= N_MASTERS.

Ports:
- clk_in  in  1  system clock, rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- m_req  in  N_MASTERS  per-master access request, held until acked.
- m_wr  in  N_MASTERS  1=write, 0=read.
- m_a  in  32*N_MASTERS  packed byte addresses; master k at [32k+31:32k].
- m_dout  in  8*N_MASTERS  packed write data.
- m_burst  in  N_MASTERS  request to keep the grant after this access.
- m_ack  out  N_MASTERS  one-hot; access accepted this cycle.
- m_rvalid  out  N_MASTERS  one-hot; m_din is valid read data for that master.
- m_din  out  8  shared read-data return.
- ram_en  out  1  RAM access strobe.
- ram_r_nw  out  1  1=read, 0=write.
- ram_a  out  RAM_ADDR_WIDTH  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, 1-cycle synchronous.
- io_en  out  1  IO access strobe.
- io_sel  out  3  IO register select, equal to addr[2:0].
- io_wr  out  1  IO write.
- io_din  out  8  IO write data.
- io_dout  in  8  IO read data, valid the cycle after io_en.
- io_full  in  1  IO transmit buffer full.
- grant_id  out  ID_W  index of the current or last granted master.

Behaviour:
- Reset (async): rr_ptr=0, lock=0, grant_id=0, pending-read regs cleared. All outputs go to 0: m_ack, m_rvalid, ram_en, io_en, io_wr, m_din.
- Arbitration is combinational from registered state.
  - Locked: only the lock owner can be granted.
  - Unlocked: round-robin search starting at rr_ptr picks the first master with m_req=1.
- Acceptance of winner k in cycle T:
  - m_ack[k]=1 and the bus is driven combinationally in cycle T.
  - rr_ptr <= (k+1) mod N_MASTERS; grant_id <= k.
- IO decode: the access is IO when addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11, otherwise RAM.
  - RAM access: ram_en=1, ram_a=addr[RAM_ADDR_WIDTH-1:0].
  - IO access: io_en=1, io_sel=addr[2:0].
  - Only the accepted access drives strobes; both strobes are 0 otherwise.
- IO write stall: if the winner is an IO write and io_full=1, then m_ack=0, io_en=0, the lock is unchanged and the master keeps waiting. No other master is granted that cycle; the winner keeps priority.
  - IO reads and RAM accesses are never stalled by io_full.
- Read return: a read accepted in T gives m_rvalid[k]=1 in T+1.
  - m_din = io_dout if the registered region flag is IO, else ram_dout.
  - The region flag is registered at T, so a new access in T+1 never corrupts the returned data.
  - Back-to-back reads give one rvalid per cycle.
- Writes produce no rvalid.
- Burst lock:
  - m_burst[k]=1 at ack sets lock=1 with owner k.
  - The lock clears on an ack with m_burst[k]=0, or when the owner drops m_req while locked.
  - A dropped m_req releases the lock in that same cycle, and round-robin resumes the same cycle.
- N_MASTERS=1: the arbiter degenerates to pass-through; the lock has no effect.
- Reset mid-read: any pending rvalid is discarded and never issued.

Optional Feature:
- Macro: MEM_ROUTER_PERF_EN.
- Defined: adds output ports perf_ram_cnt [31:0], perf_io_cnt [31:0] and perf_stall_cnt [31:0].
  - The counters increment on an accepted RAM access, an accepted IO access, and each io_full stall cycle respectively.
  - They wrap at 2**32 and reset to 0 on rst_in.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_in mid-read from master 0 -> all outputs 0, no m_rvalid after release, rr_ptr=0.
- RAM read: m_req[0]=1, m_wr=0, m_a=32'h0000_1000, ram returns 8'hA5 -> m_ack[0] in T with ram_a=17'h01000; m_rvalid[0]=1 and m_din=8'hA5 in T+1.
- IO stall: m_req[1] writes 8'h41 to 32'h0003_0000 with io_full=1 for 3 cycles -> no ack and io_en=0 for those 3 cycles; ack, io_en=1 and io_din=8'h41 on the cycle io_full drops.
- Round robin: both masters request RAM reads continuously -> acks alternate 0,1,0,1; rvalid one-hot matches the acked master one cycle later.
- Burst lock: master 1 does 4 accesses with m_burst=1,1,1,0 while master 0 requests -> 4 consecutive m_ack[1], then m_ack[0].
- Mixed return: IO read (io_dout=8'h33) in T, RAM read (ram_dout=8'h77) in T+1 -> m_din=8'h33 at T+1 and 8'h77 at T+2.
